dmem_arbiter: RTL and testbench

// Shares the single-port data memory between the pipeline's stage-2 load/store port (core) and an

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port DMEM between the core load/store port and an external requester.
// Core wins by default; a starvation counter forces bounded external bursts that stall the core.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int EXT_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_mem_en,
  input  logic                  core_store_en,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  dmem_en,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(EXT_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [BW-1:0] BURST_MAX  = BW'(EXT_BURST);

  typedef enum logic {ST_CORE, ST_EXT} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          rd_pend;
  logic          grant_core, grant_ext;

  function automatic logic [SW-1:0] starve_sat_inc(input logic [SW-1:0] cnt);
    return (cnt == STARVE_MAX) ? cnt : cnt + SW'(1);
  endfunction

  // Stage 0: grant decision from live requests and registered arbitration state
  always_comb begin
    grant_core = 1'b0;
    grant_ext  = 1'b0;
    state_nxt  = state;
    starve_nxt = starve_cnt;
    burst_nxt  = burst_cnt;
    case (state)
      ST_EXT: begin
        if (ext_req && (burst_cnt < BURST_MAX)) begin
          grant_ext = 1'b1;
          burst_nxt = burst_cnt + BW'(1);
        end else begin
          // Burst over: the core gets this very cycle; an idle core still lets ext in
          state_nxt  = ST_CORE;
          burst_nxt  = '0;
          starve_nxt = '0;
          if (core_mem_en) grant_core = 1'b1;
          else if (ext_req) grant_ext = 1'b1;
        end
      end
      default: begin
        if (ext_req && (starve_cnt == STARVE_MAX)) begin
          grant_ext  = 1'b1;
          state_nxt  = ST_EXT;
          burst_nxt  = BW'(1);
          starve_nxt = '0;
        end else if (core_mem_en) begin
          grant_core = 1'b1;
          starve_nxt = ext_req ? starve_sat_inc(starve_cnt) : '0;
        end else if (ext_req) begin
          grant_ext  = 1'b1;
          starve_nxt = '0;
        end else begin
          starve_nxt = '0;
        end
      end
    endcase
  end

  always_comb begin
    core_stall = 1'b0;
    ext_gnt    = 1'b0;
    dmem_en    = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (rst) begin
      core_stall = core_mem_en && !grant_core;
      ext_gnt    = grant_ext;
      dmem_en    = grant_core || grant_ext;
      if (grant_core) begin
        dmem_we    = core_store_en;
        dmem_addr  = core_addr;
        dmem_wdata = core_wdata;
      end else if (grant_ext) begin
        dmem_we    = ext_we;
        dmem_addr  = ext_addr;
        dmem_wdata = ext_wdata;
      end
    end
  end

  // Stage 1: arbitration state and ext read-return tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_CORE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
      rd_pend    <= grant_ext && !ext_we;
    end
  end

  assign ext_rvalid = rst && rd_pend;
  assign ext_rdata  = dmem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, all checked every cycle
// against a counting reference model and a reference copy of the memory contents.
module tb_dmem_arbiter;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SL = 4;
  localparam int EB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_mem_en, core_store_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_stall;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          dmem_en, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;

  logic [DW-1:0] mem     [256] = '{default: '0};
  logic [DW-1:0] ref_mem [256] = '{default: '0};

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .EXT_BURST(EB)) dut (
    .clk(clk), .rst(rst),
    .core_mem_en(core_mem_en), .core_store_en(core_store_en), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  // DMEM macro: synchronous write, registered read
  always @(posedge clk) begin
    if (dmem_en) begin
      if (dmem_we) mem[dmem_addr[7:0]] <= dmem_wdata;
      else         dmem_rdata <= mem[dmem_addr[7:0]];
    end
  end

  typedef enum int {OWN_NONE, OWN_CORE, OWN_EXT} owner_t;

  int            checks = 0;
  int            errors = 0;
  bit            forced;
  int            starve, grants;
  bit            m_rd_pend;
  logic [DW-1:0] m_rd_data;
  owner_t        own;
  logic          last_gnt, last_stall, last_en, last_we, last_rvalid;
  logic [DW-1:0] last_rdata;
  logic [13:0]   pat;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic owner_t predict();
    if (!rst) return OWN_NONE;
    if (forced) begin
      if (ext_req && grants < EB) return OWN_EXT;
    end else if (ext_req && starve >= SL) begin
      return OWN_EXT;
    end
    if (core_mem_en) return OWN_CORE;
    if (ext_req) return OWN_EXT;
    return OWN_NONE;
  endfunction

  task automatic model_update();
    if (!rst) begin
      forced = 0; starve = 0; grants = 0; m_rd_pend = 0;
      return;
    end
    m_rd_pend = (own == OWN_EXT) && !ext_we;
    if (m_rd_pend) m_rd_data = ref_mem[ext_addr[7:0]];
    if (own == OWN_CORE && core_store_en) ref_mem[core_addr[7:0]] = core_wdata;
    if (own == OWN_EXT && ext_we) ref_mem[ext_addr[7:0]] = ext_wdata;
    if (forced) begin
      if (ext_req && grants < EB) grants++;
      else begin forced = 0; grants = 0; starve = 0; end
    end else if (ext_req && starve >= SL) begin
      forced = 1; grants = 1; starve = 0;
    end else if (ext_req && own != OWN_EXT) begin
      starve = (starve + 1 > SL) ? SL : starve + 1;
    end else begin
      starve = 0;
    end
  endtask

  task automatic cycle();
    logic [DW-1:0] e_addr, e_wdata;
    logic          e_we;
    @(negedge clk);
    own = predict();
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (own == OWN_CORE) begin e_we = core_store_en; e_addr = 64'(core_addr); e_wdata = core_wdata; end
    if (own == OWN_EXT)  begin e_we = ext_we;        e_addr = 64'(ext_addr);  e_wdata = ext_wdata;  end
    last_gnt = ext_gnt; last_stall = core_stall; last_en = dmem_en; last_we = dmem_we;
    last_rvalid = ext_rvalid; last_rdata = ext_rdata;
    check("ext_gnt",    64'(ext_gnt),    64'(own == OWN_EXT));
    check("core_stall", 64'(core_stall), 64'(rst && core_mem_en && own != OWN_CORE));
    check("dmem_en",    64'(dmem_en),    64'(own != OWN_NONE));
    check("dmem_we",    64'(dmem_we),    64'(e_we));
    check("dmem_addr",  64'(dmem_addr),  e_addr);
    check("dmem_wdata", dmem_wdata,      e_wdata);
    check("ext_rvalid", 64'(ext_rvalid), 64'(rst && m_rd_pend));
    if (rst && m_rd_pend) check("ext_rdata", ext_rdata, m_rd_data);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit men, input bit mst, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input bit er, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    core_mem_en = men; core_store_en = mst; core_addr = ma; core_wdata = md;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 32'h10, 64'h55, 1, 1, 32'h20, 64'h66);
    forced = 0; starve = 0; grants = 0; m_rd_pend = 0; m_rd_data = '0;

    // Reset with every request asserted
    repeat (2) begin
      cycle();
      check("rst_en",     64'(last_en),     64'(0));
      check("rst_gnt",    64'(last_gnt),    64'(0));
      check("rst_stall",  64'(last_stall),  64'(0));
      check("rst_rvalid", 64'(last_rvalid), 64'(0));
    end
    rst = 1'b1;

    // Core-only write then read
    drive(1, 1, 32'h10, 64'hDEAD_BEEF, 0, 0, '0, '0);
    cycle();
    check("core_wr_we", 64'(last_we), 64'(1));
    drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
    cycle();
    check("core_rd_we",    64'(last_we),    64'(0));
    check("core_rd_stall", 64'(last_stall), 64'(0));
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();
    check("core_no_rvalid", 64'(last_rvalid), 64'(0));

    // Ext in idle slots: write then read back 0x20
    drive(0, 0, '0, '0, 1, 1, 32'h20, 64'hCAFE_F00D_1234_5678);
    cycle();
    check("ext_wr_gnt", 64'(last_gnt), 64'(1));
    drive(0, 0, '0, '0, 1, 0, 32'h20, '0);
    cycle();
    check("ext_rd_gnt", 64'(last_gnt), 64'(1));
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();
    check("ext_rvalid_1", 64'(last_rvalid), 64'(1));
    check("ext_rdata_20", last_rdata, 64'hCAFE_F00D_1234_5678);

    // Starvation: 4 denied, 4 forced grants, 5 core cycles, forced again
    pat = 14'b1_00000_1111_0000;
    drive(1, 0, 32'h10, '0, 1, 0, 32'h10, '0);
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("starve_gnt",   64'(last_gnt),   64'(pat[i]));
      check("starve_stall", 64'(last_stall), 64'(pat[i]));
    end

    // Early burst end: second forced grant, then ext drops
    cycle();
    check("early_gnt2", 64'(last_gnt), 64'(1));
    drive(1, 0, 32'h10, '0, 0, 0, '0, '0);
    cycle();
    check("early_stall", 64'(last_stall), 64'(0));
    check("early_en",    64'(last_en),    64'(1));
    cycle();
    check("early_core", 64'(last_stall), 64'(0));

    // Reset in the middle of a forced burst right after an ext read grant
    drive(1, 0, 32'h10, '0, 1, 0, 32'h20, '0);
    repeat (4) cycle();
    cycle();
    check("mid_gnt", 64'(last_gnt), 64'(1));
    rst = 1'b0;
    cycle();
    check("mid_rst_rvalid", 64'(last_rvalid), 64'(0));
    rst = 1'b1;
    cycle();
    check("mid_post_rvalid", 64'(last_rvalid), 64'(0));
    check("mid_post_stall",  64'(last_stall),  64'(0));
    check("mid_post_gnt",    64'(last_gnt),    64'(0));
    check("mid_post_en",     64'(last_en),     64'(1));

    // Randomized traffic; ext holds its request until granted, with occasional drops
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      core_mem_en   = ($urandom_range(0, 3) != 0);
      core_store_en = 1'($urandom_range(0, 1));
      core_addr     = AW'($urandom_range(0, 15));
      core_wdata    = {$urandom, $urandom};
      if (!(ext_req && !last_gnt && $urandom_range(0, 15) != 0)) begin
        ext_req   = 1'($urandom_range(0, 1));
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = AW'($urandom_range(0, 15));
        ext_wdata = {$urandom, $urandom};
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
